// File: rtl/pc_unit_if.sv
// Purpose : fetch-side bus between the IF-stage controller and the program-counter unit.
// Signals : write_en, exc_req, br_taken, br_target, call, ret (controller -> pc unit);
//           pc, pc_plus, pc_valid, br_pending, ras_empty (pc unit -> fetch / later stages).
// Modports: master = controller side, slave = pc_unit side.
interface pc_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             write_en;
    logic             exc_req;
    logic             br_taken;
    logic [WIDTH-1:0] br_target;
    logic             call;
    logic             ret;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus;
    logic             pc_valid;
    logic             br_pending;
    logic             ras_empty;

    modport master (
        output write_en, exc_req, br_taken, br_target, call, ret,
        input  pc, pc_plus, pc_valid, br_pending, ras_empty
    );

    modport slave (
        input  write_en, exc_req, br_taken, br_target, call, ret,
        output pc, pc_plus, pc_valid, br_pending, ras_empty
    );
endinterface

// File: rtl/pc_unit.sv
// Purpose : program-counter unit for the IF stage. Prioritised next-PC selection
//           (exception > branch/held branch > RAS return > sequential), holds a branch
//           resolved during a stall until write_en releases, aligns every loaded target.
// Ports   : clk  - rising-edge clock
//           clrn - asynchronous active-low reset
//           bus  - pc_unit_if.slave (controls in; pc, pc_plus, pc_valid, br_pending,
//                  ras_empty out). pc_plus is combinational (pc + INC); the rest are registered.
// Options : define PC_RAS_EN to build the circular return-address stack; without it
//           call/ret are ignored and ras_empty is held at 1.
module pc_unit #(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0180),
    parameter int unsigned      INC          = 4,
    parameter int unsigned      RAS_DEPTH    = 4
) (
    input logic         clk,
    input logic         clrn,
    pc_unit_if.slave    bus
);

    // Clears the low log2(INC) bits of a loaded target
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(INC - 1));

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_PEND = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [WIDTH-1:0] pc_plus_c;
    logic             pc_valid_q;
    logic             br_pending_q;
    logic             ras_empty_q, ras_empty_d;
    logic             seq_slot_c;
    logic             ret_hit_c;
    logic [WIDTH-1:0] ras_top_c;

    assign pc_plus_c = pc_q + WIDTH'(INC);

    // Cycle where the PC advances with no exception or branch; only here may the RAS act
    assign seq_slot_c = (state_q == S_RUN) && bus.write_en && !bus.exc_req && !bus.br_taken;

    // Next-state / next-PC selection
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (bus.exc_req) begin
                    pc_d = EXC_VECTOR;
                end else if (bus.write_en) begin
                    if (bus.br_taken) begin
                        pc_d = bus.br_target & ALIGN_MASK;
                    end else if (ret_hit_c) begin
                        pc_d = ras_top_c;
                    end else begin
                        pc_d = pc_plus_c;
                    end
                end else if (bus.br_taken) begin
                    tgt_d   = bus.br_target & ALIGN_MASK;
                    state_d = S_PEND;
                end
            end
            S_PEND: begin
                if (bus.exc_req) begin
                    pc_d    = EXC_VECTOR;
                    tgt_d   = '0;
                    state_d = S_RUN;
                end else if (bus.write_en) begin
                    // A branch resolving in the release cycle is younger than the held one
                    pc_d    = bus.br_taken ? (bus.br_target & ALIGN_MASK) : tgt_q;
                    state_d = S_RUN;
                end else if (bus.br_taken) begin
                    tgt_d = bus.br_target & ALIGN_MASK;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q      <= S_BOOT;
            pc_q         <= RESET_VECTOR;
            tgt_q        <= '0;
            pc_valid_q   <= 1'b0;
            br_pending_q <= 1'b0;
            ras_empty_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            tgt_q        <= tgt_d;
            pc_valid_q   <= (state_d != S_BOOT);
            br_pending_q <= (state_d == S_PEND);
            ras_empty_q  <= ras_empty_d;
        end
    end

`ifdef PC_RAS_EN
    localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]    ras_ptr_q, ras_ptr_d;
    logic [CW-1:0]    ras_cnt_q, ras_cnt_d;
    logic [PW-1:0]    top_idx_c;
    logic [PW-1:0]    wr_idx_c;
    logic             ras_we_c;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (32'(p) == RAS_DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
        return (p == '0) ? PW'(RAS_DEPTH - 1) : p - PW'(1);
    endfunction

    // ras_ptr_q is the next free slot; the top of stack sits just below it
    assign top_idx_c = ptr_dec(ras_ptr_q);
    assign ras_top_c = ras_mem[top_idx_c] & ALIGN_MASK;
    assign ret_hit_c = seq_slot_c && bus.ret && (ras_cnt_q != '0);

    // Push/pop bookkeeping; a full stack overwrites its oldest entry
    always_comb begin
        ras_ptr_d = ras_ptr_q;
        ras_cnt_d = ras_cnt_q;
        ras_we_c  = 1'b0;
        wr_idx_c  = ras_ptr_q;
        if (ret_hit_c && bus.call) begin
            ras_we_c = 1'b1;
            wr_idx_c = top_idx_c;
        end else if (ret_hit_c) begin
            ras_ptr_d = top_idx_c;
            ras_cnt_d = ras_cnt_q - CW'(1);
        end else if (seq_slot_c && bus.call) begin
            ras_we_c  = 1'b1;
            wr_idx_c  = ras_ptr_q;
            ras_ptr_d = ptr_inc(ras_ptr_q);
            if (ras_cnt_q != CW'(RAS_DEPTH)) begin
                ras_cnt_d = ras_cnt_q + CW'(1);
            end
        end
        ras_empty_d = (ras_cnt_d == '0);
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
        end else begin
            ras_ptr_q <= ras_ptr_d;
            ras_cnt_q <= ras_cnt_d;
        end
    end

    // Stack storage needs no reset: count gates every read
    always_ff @(posedge clk) begin
        if (ras_we_c) begin
            ras_mem[wr_idx_c] <= pc_plus_c;
        end
    end
`else
    assign ret_hit_c   = 1'b0;
    assign ras_top_c   = '0;
    assign ras_empty_d = 1'b1;

    logic unused_ras;
    assign unused_ras = &{1'b0, bus.call, bus.ret, seq_slot_c, 32'(RAS_DEPTH)};
`endif

    assign bus.pc         = pc_q;
    assign bus.pc_plus    = pc_plus_c;
    assign bus.pc_valid   = pc_valid_q;
    assign bus.br_pending = br_pending_q;
    assign bus.ras_empty  = ras_empty_q;

endmodule
